// File: rtl/det_pkg.sv
// Shared types and defaults for the round-robin arbiter and its
// equal-consecutive-bits detector core.
package det_pkg;

  localparam int NREQ_DEF = 4;
  localparam int CNTW_DEF = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_STREAM,
    ARB_DONE
  } arb_state_t;

  // A is the post-grant start state; Bx = one bit x seen, Cx = run of x.
  typedef enum logic [2:0] {
    CORE_A,
    CORE_B0,
    CORE_C0,
    CORE_B1,
    CORE_C1
  } core_state_t;

  function automatic core_state_t core_next(input core_state_t s, input logic w);
    core_state_t n;
    if (!w) begin
      n = (s == CORE_B0 || s == CORE_C0) ? CORE_C0 : CORE_B0;
    end else begin
      n = (s == CORE_B1 || s == CORE_C1) ? CORE_C1 : CORE_B1;
    end
    return n;
  endfunction

  function automatic logic core_is_match(input core_state_t s);
    return (s == CORE_C0) || (s == CORE_C1);
  endfunction

endpackage

// File: rtl/det_core.sv
// Moore detector: q is high once two or more equal consecutive bits have
// been seen; next_match previews that for the bit currently on w.
module det_core
  import det_pkg::*;
(
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  input  logic w,
  output logic q,
  output logic next_match
);

  core_state_t r_state;
  core_state_t w_state_nxt;

  always_comb begin
    w_state_nxt = core_next(r_state, w);
    next_match  = core_is_match(w_state_nxt);
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= CORE_A;
    end else if (clr) begin
      r_state <= CORE_A;
    end else if (en) begin
      r_state <= w_state_nxt;
    end
  end

  assign q = core_is_match(r_state);

endmodule

// File: rtl/det_arbiter.sv
// Round-robin arbiter that lends one shared detector core to a requester
// for a whole serial frame and reports the frame's match count.
module det_arbiter
  import det_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] w_in,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            q,
  output logic [CNTW-1:0] hit_cnt,
  output logic            done,
  output logic [1:0]      done_id,
  output logic            abort
);

  // Requester indices are 2 bits, so pointer arithmetic wraps 3->0 for free.
  typedef logic [1:0] idx_t;

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  idx_t            r_owner;
  idx_t            r_ptr;
  idx_t            w_winner;
  logic            w_found;
  logic            r_abort;
  logic [CNTW-1:0] r_hit_cnt;

  logic w_grant;
  logic w_sample;
  logic w_finish;
  logic w_abort_nxt;
  logic w_own_req;
  logic w_own_last;
  logic w_own_bit;
  logic w_next_match;

  assign w_own_req  = req[r_owner];
  assign w_own_last = last[r_owner];
  assign w_own_bit  = w_in[r_owner];

  always_comb begin
    w_winner = r_ptr;
    w_found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[r_ptr + idx_t'(i)]) begin
        w_winner = r_ptr + idx_t'(i);
        w_found  = 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_sample    = 1'b0;
    w_finish    = 1'b0;
    w_abort_nxt = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = ARB_STREAM;
        end
      end
      ARB_STREAM: begin
        // last wins over a simultaneous req drop: the bit still counts.
        if (w_own_last) begin
          w_sample = 1'b1;
          w_finish = 1'b1;
        end else if (!w_own_req) begin
          w_finish    = 1'b1;
          w_abort_nxt = 1'b1;
        end else begin
          w_sample = 1'b1;
        end
        if (w_finish) begin
          w_state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: begin
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state   <= ARB_IDLE;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_abort   <= 1'b0;
      r_hit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner   <= w_winner;
        r_hit_cnt <= '0;
      end else if (w_sample && w_next_match && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + CNTW'(1);
      end
      if (w_finish) begin
        r_abort <= w_abort_nxt;
        r_ptr   <= r_owner + idx_t'(1);
      end
    end
  end

  det_core u_core (
    .clk        (clk),
    .Reset      (Reset),
    .clr        (w_grant),
    .en         (w_sample),
    .w          (w_own_bit),
    .q          (q),
    .next_match (w_next_match)
  );

  always_comb begin
    gnt = '0;
    if (r_state == ARB_STREAM) begin
      gnt[r_owner] = 1'b1;
    end
  end

  assign busy    = (r_state != ARB_IDLE);
  assign done    = (r_state == ARB_DONE);
  assign done_id = done ? r_owner : 2'd0;
  assign abort   = done & r_abort;
  assign hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_det_arbiter.sv
// Bench for det_arbiter: directed scenarios plus a randomized run, all
// checked against a frame-level model (bit history + owner bookkeeping).
module tb_det_arbiter;

  localparam int NREQ = 4;
  localparam int CNTW = 8;
  localparam int SAT  = 255;

  logic            clk = 1'b0;
  logic            Reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] w_in;
  logic [NREQ-1:0] last;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic            q;
  logic [CNTW-1:0] hit_cnt;
  logic            done;
  logic [1:0]      done_id;
  logic            abort;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: who owns the core (-1 none), whether we are in the completion
  // cycle, and the bits of the current/last frame.
  int m_owner   = -1;
  bit m_in_done = 1'b0;
  bit m_abort   = 1'b0;
  int m_ptr     = 0;
  int m_pairs   = 0;
  bit m_bits[$];

  det_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .req     (req),
    .w_in    (w_in),
    .last    (last),
    .gnt     (gnt),
    .busy    (busy),
    .q       (q),
    .hit_cnt (hit_cnt),
    .done    (done),
    .done_id (done_id),
    .abort   (abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bit(input bit b);
    if (m_bits.size() > 0 && m_bits[m_bits.size()-1] == b) m_pairs++;
    m_bits.push_back(b);
  endtask

  task automatic model_step(input bit rst, input logic [3:0] rq, input logic [3:0] wi,
                            input logic [3:0] la);
    if (rst) begin
      m_owner = -1; m_in_done = 0; m_abort = 0; m_ptr = 0; m_pairs = 0;
      m_bits.delete();
    end else if (m_in_done) begin
      m_in_done = 0;
      m_owner   = -1;
    end else if (m_owner < 0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_owner < 0 && rq[(m_ptr + i) % NREQ]) m_owner = (m_ptr + i) % NREQ;
      end
      if (m_owner >= 0) begin
        m_bits.delete();
        m_pairs = 0;
      end
    end else if (la[m_owner]) begin
      push_bit(wi[m_owner]);
      m_in_done = 1; m_abort = 0; m_ptr = (m_owner + 1) % NREQ;
    end else if (!rq[m_owner]) begin
      m_in_done = 1; m_abort = 1; m_ptr = (m_owner + 1) % NREQ;
    end else begin
      push_bit(wi[m_owner]);
    end
  endtask

  task automatic check_all();
    logic [3:0] e_gnt;
    bit         e_q;
    int         n;
    n     = m_bits.size();
    e_gnt = (m_owner >= 0 && !m_in_done) ? 4'(1 << m_owner) : 4'd0;
    e_q   = (n >= 2) && (m_bits[n-1] == m_bits[n-2]);
    check("gnt",     32'(gnt),     32'(e_gnt));
    check("busy",    32'(busy),    32'(m_owner >= 0));
    check("q",       32'(q),       32'(e_q));
    check("hit_cnt", 32'(hit_cnt), 32'((m_pairs > SAT) ? SAT : m_pairs));
    check("done",    32'(done),    32'(m_in_done));
    check("done_id", 32'(done_id), m_in_done ? 32'(m_owner) : 32'd0);
    check("abort",   32'(abort),   32'(m_in_done && m_abort));
  endtask

  task automatic cycle(input bit rst, input logic [3:0] rq, input logic [3:0] wi,
                       input logic [3:0] la);
    Reset = rst; req = rq; w_in = wi; last = la;
    @(posedge clk);
    model_step(rst, rq, wi, la);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    logic [3:0] gnt_log[$];
    logic [3:0] exp_order[5];
    logic [3:0] bits033;
    logic [3:0] rq_hold;
    logic [3:0] la_r;

    // Reset for 5 cycles with requests present, then release with req=0.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'hF, 4'($urandom), 4'hF);
    cycle(1'b0, 4'h0, 4'h0, 4'h0);
    check("rst_gnt",     32'(gnt),     32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_q",       32'(q),       32'd0);
    check("rst_hit",     32'(hit_cnt), 32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_abort",   32'(abort),   32'd0);

    // Requester 2 sends 0,0,0,1,1 (LSB first here) -> three matches.
    bits033 = 4'b1000;
    cycle(1'b0, 4'b0100, 4'h0, 4'h0);
    check("f2_gnt_0", 32'(gnt), 32'h4);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b0100, (i >= 3) ? 4'b0100 : 4'b0000, (i == 4) ? 4'b0100 : 4'b0000);
      if (i < 4) check("f2_gnt", 32'(gnt), 32'h4);
    end
    check("f2_done",    32'(done),    32'd1);
    check("f2_done_id", 32'(done_id), 32'd2);
    check("f2_hit",     32'(hit_cnt), 32'd3);
    check("f2_abort",   32'(abort),   32'd0);
    check("f2_gnt_off", 32'(gnt),     32'd0);
    cycle(1'b0, 4'h0, 4'h0, 4'h0);
    check("f2_hold_hit", 32'(hit_cnt), 32'd3);
    check("f2_pad", 32'(bits033), 32'h8);

    // Requester 1 sends 1,1 then drops req -> aborted frame with one match.
    idle(2);
    cycle(1'b0, 4'b0010, 4'h0, 4'h0);
    cycle(1'b0, 4'b0010, 4'b0010, 4'h0);
    cycle(1'b0, 4'b0010, 4'b0010, 4'h0);
    cycle(1'b0, 4'b0000, 4'h0, 4'h0);
    check("ab_done",    32'(done),    32'd1);
    check("ab_abort",   32'(abort),   32'd1);
    check("ab_done_id", 32'(done_id), 32'd1);
    check("ab_hit",     32'(hit_cnt), 32'd1);

    // Reset on the third bit of a frame from requester 2.
    idle(2);
    cycle(1'b0, 4'b0100, 4'h0, 4'h0);
    cycle(1'b0, 4'b0100, 4'b0100, 4'h0);
    cycle(1'b0, 4'b0100, 4'b0100, 4'h0);
    cycle(1'b1, 4'b0100, 4'b0100, 4'h0);
    check("mr_gnt",  32'(gnt),     32'd0);
    check("mr_hit",  32'(hit_cnt), 32'd0);
    check("mr_done", 32'(done),    32'd0);
    cycle(1'b0, 4'hF, 4'h0, 4'h0);
    check("mr_next_gnt", 32'(gnt), 32'h1);
    idle(3);

    // All requesting with single-bit frames, starting from ptr=0.
    cycle(1'b1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 4'hF, 4'($urandom), 4'hF);
      if (gnt != 4'h0) gnt_log.push_back(gnt);
      if (done) check("rr_hit", 32'(hit_cnt), 32'd0);
    end
    exp_order = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    for (int i = 0; i < 5; i++) begin
      check("rr_order", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF, 32'(exp_order[i]));
    end
    idle(3);

    // 300 ones in one frame saturate the counter.
    cycle(1'b0, 4'b0001, 4'h0, 4'h0);
    for (int i = 0; i < 300; i++) cycle(1'b0, 4'b0001, 4'b0001, (i == 299) ? 4'b0001 : 4'b0000);
    check("sat_done", 32'(done),    32'd1);
    check("sat_hit",  32'(hit_cnt), 32'd255);
    idle(2);

    // Randomized traffic: held request sets, random last, rare resets.
    rq_hold = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) rq_hold = 4'($urandom);
      la_r = 4'h0;
      for (int b = 0; b < NREQ; b++) if ($urandom_range(0, 5) == 0) la_r[b] = 1'b1;
      cycle($urandom_range(0, 199) == 0, rq_hold, 4'($urandom), la_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/det_arbiter.md
DET_ARBITER -- requirements
Module: det_arbiter

Interface
REQ-001 The block SHALL have the parameter NREQ, default 4, giving the number of requesters; it is fixed at 4 in this revision.
REQ-002 The block SHALL have the parameter CNTW, default 8, giving the width of the hit counter.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port Reset, input, 1 bit: a synchronous, active-high reset.
REQ-005 The block SHALL have the port req, input, NREQ bits: per-requester request, held high for the whole frame.
REQ-006 The block SHALL have the port w_in, input, NREQ bits: per-requester serial data bit.
REQ-007 The block SHALL have the port last, input, NREQ bits: per-requester flag marking the final bit of the frame.
REQ-008 The block SHALL have the port gnt, output, NREQ bits: one-hot grant, or all zero.
REQ-009 The block SHALL have the port busy, output, 1 bit: high when the arbiter state is not IDLE.
REQ-010 The block SHALL have the port q, output, 1 bit: the shared detector's Moore output.
REQ-011 The block SHALL have the port hit_cnt, output, CNTW bits: the match count for the current or finished frame.
REQ-012 The block SHALL have the port done, output, 1 bit: a one-cycle frame-complete pulse.
REQ-013 The block SHALL have the port done_id, output, 2 bits: the index of the requester that finished.
REQ-014 The block SHALL have the port abort, output, 1 bit: qualifies done when the frame ended because req dropped.

Function
REQ-015 Detector core SHALL be a Moore FSM with states A(start), B0, C0, B1, C1:
- From any state, w=0 SHALL move to B0, except from B0 or C0, which SHALL move to C0.
- From any state, w=1 SHALL move to B1, except from B1 or C1, which SHALL move to C1.
- q=1 only in C0/C1 (two or more equal consecutive bits).
REQ-016 Arbiter FSM states SHALL be IDLE, STREAM, DONE.
REQ-017 In IDLE with req!=0:
- Select the first set req bit at or after round-robin pointer ptr (wrapping 3->0).
- Next cycle: gnt one-hot for the winner, state STREAM, core forced to A, hit_cnt cleared.
REQ-018 In STREAM, each cycle SHALL:
- Sample w_in[owner] into the core.
- Increment hit_cnt when the core's next state is C0 or C1, saturating at 2^CNTW-1.
REQ-019 In STREAM, a sampled cycle with last[owner]=1 SHALL be the final bit; next state DONE.
REQ-020 In STREAM, if req[owner]=0, no bit SHALL be sampled; next state DONE with abort=1.
REQ-021 In DONE, for exactly one cycle:
- done=1, done_id=owner, gnt=0.
- hit_cnt holds the frame total.
- ptr=owner+1 mod 4.
- Next state IDLE.
REQ-022 A new grant SHALL NOT issue in the DONE cycle; minimum gap between frames is one IDLE cycle.
REQ-023 Requests arriving during STREAM/DONE SHALL wait; req/w_in/last of non-owners SHALL be ignored.
REQ-024 last[owner] and req drop in the same cycle SHALL be treated as normal completion (abort=0, bit sampled).
REQ-025 hit_cnt and q SHALL hold their values in IDLE until the next grant.
REQ-026 A single-bit frame (last=1 on first STREAM cycle) SHALL give hit_cnt=0.

Reset
REQ-027 Reset=1 at a clock edge SHALL force, regardless of current state including mid-frame:
- State IDLE, core A, ptr=0.
- gnt=0, busy=0, q=0, hit_cnt=0, done=0, done_id=0, abort=0.
- No done pulse for the interrupted frame.
REQ-028 The block SHALL ignore req while Reset=1.

Structure
REQ-029 Shared package det_pkg SHALL hold:
- Arbiter and core state enumerations.
- NREQ and CNTW defaults.
REQ-030 Detector core SHALL be sub-module det_core with ports clk, Reset, clr, en, w, q, and a combinational next-is-match output.
REQ-031 Arbiter FSM, RR pointer and counter SHALL live in det_arbiter.

Verification
REQ-032 Reset held 5 cycles, then released, req=0 -> all outputs 0, busy=0.
REQ-033 req[2]=1, bits 0,0,0,1,1 with last on the 5th -> gnt=0100 for 5 cycles; done_id=2, hit_cnt=3, abort=0.
REQ-034 req=1111 continuously, 1-bit frames, ptr=0 -> grant order 0,1,2,3,0 with one IDLE cycle between frames.
REQ-035 req[1] dropped after bits 1,1 -> done=1, abort=1, done_id=1, hit_cnt=1.
REQ-036 Reset asserted mid-frame on bit 3 -> gnt=0, hit_cnt=0 next cycle; no done; next grant from requester 0.
REQ-037 300 consecutive 1s, CNTW=8 -> hit_cnt saturates at 255.
